// File: rtl/data_mem_resp.sv
// Data-memory responder for the memory-access stage.
// Serves one read or write at a time against an internal DEPTH x DATA_W array.
// Read/write strobes are rising-edge significant. Reads take READ_LAT cycles.
// Every completion gives a one-cycle READY pulse. Illegal or colliding requests
// give a one-cycle ERR pulse and bump a saturating error counter.
//
// Ports:
//   CLK                 system clock, all state updates on the rising edge
//   RST                 synchronous reset, active-high
//   MEM_DATA_ADDR       access address, latched on the accepted request edge
//   WR_DATA             write data, latched with the write request
//   MEM_DATA_CLK_READ   read request strobe (rising edge)
//   MEM_DATA_CLK_WRITE  write request strobe (rising edge)
//   MEM_DATA            data of the last completed read
//   READY               one-cycle completion pulse
//   ERR                 one-cycle error pulse
//   ERR_CNT             saturating error counter
//   ESTADO              FSM state: 0 idle, 1 read, 2 write, 3 done
module data_mem_resp #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] MEM_DATA_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              MEM_DATA_CLK_READ,
  input  logic              MEM_DATA_CLK_WRITE,
  output logic [DATA_W-1:0] MEM_DATA,
  output logic              READY,
  output logic              ERR,
  output logic [7:0]        ERR_CNT,
  output logic [2:0]        ESTADO
);

  localparam int unsigned     IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]      LastCnt  = 3'(READ_LAT - 1);
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd   = 3'd1,
    StWr   = 3'd2,
    StDone = 3'd3
  } state_e;

  state_e              state_q, state_d;
  logic                rd_q, wr_q;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                rd_rise, wr_rise;
  logic                in_range;
  logic [IdxW-1:0]     idx;
  logic                mem_we;

  assign rd_rise  = MEM_DATA_CLK_READ & ~rd_q;
  assign wr_rise  = MEM_DATA_CLK_WRITE & ~wr_q;
  assign in_range = {1'b0, addr_q} < DepthLim;
  assign idx      = addr_q[IdxW-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_data_d = mem_data_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rd_rise && wr_rise) begin
          err_d = 1'b1;
        end else if (rd_rise) begin
          addr_d  = MEM_DATA_ADDR;
          cnt_d   = 3'd0;
          state_d = StRd;
        end else if (wr_rise) begin
          addr_d  = MEM_DATA_ADDR;
          wdata_d = WR_DATA;
          state_d = StWr;
        end
      end
      StRd: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LastCnt) begin
          ready_d = 1'b1;
          state_d = StDone;
          if (in_range) begin
            mem_data_d = mem[idx];
          end else begin
            mem_data_d = '0;
            err_d      = 1'b1;
          end
        end
      end
      StWr: begin
        ready_d = 1'b1;
        state_d = StDone;
        if (in_range) mem_we = 1'b1;
        else          err_d  = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Requests arriving while busy are dropped; the current access is untouched.
    if (state_q != StIdle && (rd_rise || wr_rise)) err_d = 1'b1;

    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      // Strobes held high across reset release must not look like requests.
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      cnt_q      <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_data_q <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      rd_q       <= MEM_DATA_CLK_READ;
      wr_q       <= MEM_DATA_CLK_WRITE;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_data_q <= mem_data_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Array is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RST && mem_we) mem[idx] <= wdata_q;
  end

  assign MEM_DATA = mem_data_q;
  assign READY    = ready_q;
  assign ERR      = err_q;
  assign ERR_CNT  = err_cnt_q;
  assign ESTADO   = state_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp. Three instances cover the parameter points:
//   0: DEPTH 1024, READ_LAT 1
//   1: DEPTH 1024, READ_LAT 4
//   2: DEPTH 512,  READ_LAT 1 (out-of-range addresses)
module tb_data_mem_resp;

  logic        clk;
  logic        rst;
  logic [9:0]  addr     [3];
  logic [15:0] wdata    [3];
  logic        rd       [3];
  logic        wr       [3];
  logic [15:0] mem_data [3];
  logic        ready    [3];
  logic        err      [3];
  logic [7:0]  err_cnt  [3];
  logic [2:0]  estado   [3];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_resp #(.ADDR_W(10), .DATA_W(16), .DEPTH(1024), .READ_LAT(1)) u_dut0 (
    .CLK(clk), .RST(rst), .MEM_DATA_ADDR(addr[0]), .WR_DATA(wdata[0]),
    .MEM_DATA_CLK_READ(rd[0]), .MEM_DATA_CLK_WRITE(wr[0]), .MEM_DATA(mem_data[0]),
    .READY(ready[0]), .ERR(err[0]), .ERR_CNT(err_cnt[0]), .ESTADO(estado[0])
  );

  data_mem_resp #(.ADDR_W(10), .DATA_W(16), .DEPTH(1024), .READ_LAT(4)) u_dut1 (
    .CLK(clk), .RST(rst), .MEM_DATA_ADDR(addr[1]), .WR_DATA(wdata[1]),
    .MEM_DATA_CLK_READ(rd[1]), .MEM_DATA_CLK_WRITE(wr[1]), .MEM_DATA(mem_data[1]),
    .READY(ready[1]), .ERR(err[1]), .ERR_CNT(err_cnt[1]), .ESTADO(estado[1])
  );

  data_mem_resp #(.ADDR_W(10), .DATA_W(16), .DEPTH(512), .READ_LAT(1)) u_dut2 (
    .CLK(clk), .RST(rst), .MEM_DATA_ADDR(addr[2]), .WR_DATA(wdata[2]),
    .MEM_DATA_CLK_READ(rd[2]), .MEM_DATA_CLK_WRITE(wr[2]), .MEM_DATA(mem_data[2]),
    .READY(ready[2]), .ERR(err[2]), .ERR_CNT(err_cnt[2]), .ESTADO(estado[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int d, input logic [9:0] a, input logic [15:0] v);
    addr[d] = a; wdata[d] = v; wr[d] = 1'b1;
    tick();
    wr[d] = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_read(input int d, input logic [9:0] a, input int lat);
    addr[d] = a; rd[d] = 1'b1;
    tick();
    rd[d] = 1'b0;
    for (int i = 0; i < lat + 1; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      addr[d] = '0; wdata[d] = '0; rd[d] = 1'b1; wr[d] = 1'b1;
    end
    tick();
    tick();

    // Reset release with strobes still high: no access may start.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_estado", estado[0], 0);
      check_eq("rst_ready", ready[0], 0);
    end
    check_eq("rst_mem_data", mem_data[0], 0);
    check_eq("rst_err_cnt", err_cnt[0], 0);
    check_eq("rst_err", err[0], 0);
    for (int d = 0; d < 3; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0;
    end
    tick();

    // Write 0xBEEF @ 5; WR_DATA changes after the request edge must be ignored.
    addr[0] = 10'd5; wdata[0] = 16'hBEEF; wr[0] = 1'b1;
    tick();
    check_eq("wr_estado_wr", estado[0], 2);
    check_eq("wr_ready_early", ready[0], 0);
    wdata[0] = 16'h0000; addr[0] = 10'd9;
    tick();
    check_eq("wr_estado_done", estado[0], 3);
    check_eq("wr_ready", ready[0], 1);
    tick();
    check_eq("wr_estado_idle", estado[0], 0);
    check_eq("wr_ready_low", ready[0], 0);
    wr[0] = 1'b0;
    tick();
    tick();

    // Read addr 5 with the strobe held high throughout: exactly one request.
    addr[0] = 10'd5; rd[0] = 1'b1;
    tick();
    check_eq("rd_estado_rd", estado[0], 1);
    check_eq("rd_ready_early", ready[0], 0);
    addr[0] = 10'd7;
    tick();
    check_eq("rd_estado_done", estado[0], 3);
    check_eq("rd_ready", ready[0], 1);
    check_eq("rd_data", mem_data[0], 16'hBEEF);
    tick();
    check_eq("rd_estado_idle", estado[0], 0);
    check_eq("rd_ready_low", ready[0], 0);
    tick();
    check_eq("rd_held_no_rerun", estado[0], 0);
    rd[0] = 1'b0;
    tick();

    // READ_LAT = 4 on preloaded 0x3FF.
    do_write(1, 10'h3FF, 16'hA5A5);
    addr[1] = 10'h3FF; rd[1] = 1'b1;
    tick();
    rd[1] = 1'b0;
    check_eq("lat4_estado_rd", estado[1], 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("lat4_ready_early", ready[1], 0);
      check_eq("lat4_estado_wait", estado[1], 1);
    end
    check_eq("lat4_data_early", mem_data[1], 0);
    tick();
    check_eq("lat4_ready", ready[1], 1);
    check_eq("lat4_data", mem_data[1], 16'hA5A5);
    check_eq("lat4_estado_done", estado[1], 3);
    tick();
    check_eq("lat4_ready_pulse", ready[1], 0);
    check_eq("lat4_estado_idle", estado[1], 0);

    // Collision: both strobes rise together.
    addr[0] = 10'd5; wdata[0] = 16'h1111; rd[0] = 1'b1; wr[0] = 1'b1;
    tick();
    check_eq("coll_err", err[0], 1);
    check_eq("coll_estado", estado[0], 0);
    rd[0] = 1'b0; wr[0] = 1'b0;
    tick();
    check_eq("coll_err_pulse", err[0], 0);
    check_eq("coll_err_cnt", err_cnt[0], 1);
    tick();

    // Write strobe rising during RD is dropped; read still completes.
    addr[0] = 10'd5; rd[0] = 1'b1;
    tick();
    wr[0] = 1'b1; wdata[0] = 16'h2222;
    tick();
    check_eq("busy_err", err[0], 1);
    check_eq("busy_ready", ready[0], 1);
    check_eq("busy_rd_data", mem_data[0], 16'hBEEF);
    rd[0] = 1'b0; wr[0] = 1'b0;
    tick();
    check_eq("busy_err_cnt", err_cnt[0], 2);
    check_eq("busy_estado", estado[0], 0);
    tick();

    // Out of range on DEPTH 512: 600 would alias to 88 if truncated.
    do_write(2, 10'd88, 16'h5678);
    do_read(2, 10'd88, 1);
    check_eq("oor_pre_data", mem_data[2], 16'h5678);
    addr[2] = 10'd600; wdata[2] = 16'h1234; wr[2] = 1'b1;
    tick();
    wr[2] = 1'b0;
    tick();
    check_eq("oor_wr_ready", ready[2], 1);
    check_eq("oor_wr_err", err[2], 1);
    tick();
    check_eq("oor_wr_err_cnt", err_cnt[2], 1);
    addr[2] = 10'd600; rd[2] = 1'b1;
    tick();
    rd[2] = 1'b0;
    tick();
    check_eq("oor_rd_ready", ready[2], 1);
    check_eq("oor_rd_err", err[2], 1);
    check_eq("oor_rd_data", mem_data[2], 0);
    tick();
    check_eq("oor_rd_err_cnt", err_cnt[2], 2);
    do_read(2, 10'd88, 1);
    check_eq("oor_no_alias", mem_data[2], 16'h5678);

    // Reset on the WR commit edge: word keeps its old value.
    addr[0] = 10'd5; wdata[0] = 16'h3333; wr[0] = 1'b1;
    tick();
    check_eq("rstwr_estado_wr", estado[0], 2);
    rst = 1'b1;
    tick();
    check_eq("rstwr_estado", estado[0], 0);
    check_eq("rstwr_ready", ready[0], 0);
    check_eq("rstwr_err_cnt", err_cnt[0], 0);
    check_eq("rstwr_mem_data", mem_data[0], 0);
    rst = 1'b0; wr[0] = 1'b0;
    tick();
    do_read(0, 10'd5, 1);
    check_eq("rstwr_kept_old", mem_data[0], 16'hBEEF);

    // Error counter saturation via repeated collisions.
    for (int i = 1; i <= 300; i++) begin
      rd[0] = 1'b1; wr[0] = 1'b1;
      tick();
      rd[0] = 1'b0; wr[0] = 1'b0;
      tick();
      if (i == 254) check_eq("sat_err_cnt_254", err_cnt[0], 254);
      if (i == 255) check_eq("sat_err_cnt_255", err_cnt[0], 255);
    end
    check_eq("sat_err_cnt_300", err_cnt[0], 255);
    check_eq("sat_estado", estado[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
